// File: rtl/if_id_skid_reg_if.sv
// IF/ID handshake bundle: fetch-side input, decode-side output, flush and perf counter.
// Latency: none, wiring only.
// Backpressure: inReady/outReady carry the valid/ready handshake on each side.
interface if_id_skid_reg_if #(
  parameter int INST_W = 32,
  parameter int PC_W   = 10,
  parameter int CNT_W  = 16
);
  logic              inValid;
  logic              inReady;
  logic [INST_W-1:0] instIn;
  logic [PC_W-1:0]   NPCIn;
  logic              flush;
  logic              outValid;
  logic              outReady;
  logic [INST_W-1:0] instOut;
  logic [PC_W-1:0]   NPCOut;
  logic [CNT_W-1:0]  stallCnt;

  // Environment side: drives fetch data, flush and decode ready.
  modport master (
    output inValid, instIn, NPCIn, flush, outReady,
    input  inReady, outValid, instOut, NPCOut, stallCnt
  );

  // Pipeline register side.
  modport slave (
    input  inValid, instIn, NPCIn, flush, outReady,
    output inReady, outValid, instOut, NPCOut, stallCnt
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with one-entry skid buffer, flush and saturating stall counter.
// Latency: one cycle from in_fire to outValid; one instruction per cycle when decode is ready.
// Backpressure: inReady comes from state only; at most one extra instruction lands in skid after outReady drops.
module if_id_skid_reg #(
  parameter int                INST_W   = 32,
  parameter int                PC_W     = 10,
  parameter int                CNT_W    = 16,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
) (
  input logic clk,
  input logic reset,
  if_id_skid_reg_if.slave bus
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [INST_W-1:0] main_inst;
  logic [PC_W-1:0]   main_npc;
  logic [INST_W-1:0] skid_inst;
  logic [PC_W-1:0]   skid_npc;
  logic [CNT_W-1:0]  stall_cnt;

  logic in_rdy;
  logic out_vld;
  logic in_fire;
  logic out_fire;

  // Ready/valid decoded from registered state only, so outReady never reaches inReady.
  always_comb begin
    in_rdy   = (state != ST_TWO) & reset;
    out_vld  = (state != ST_EMPTY);
    in_fire  = bus.inValid & in_rdy;
    out_fire = out_vld & bus.outReady;
  end

  assign bus.inReady  = in_rdy;
  assign bus.outValid = out_vld;
  assign bus.instOut  = out_vld ? main_inst : NOP_INST;
  assign bus.NPCOut   = out_vld ? main_npc : {PC_W{1'b0}};
  assign bus.stallCnt = stall_cnt;

  // Occupancy state and the main/skid entries; flush empties both and drops any incoming instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EMPTY;
      main_inst <= NOP_INST;
      main_npc  <= {PC_W{1'b0}};
      skid_inst <= NOP_INST;
      skid_npc  <= {PC_W{1'b0}};
    end else if (bus.flush) begin
      state     <= ST_EMPTY;
      main_inst <= NOP_INST;
      main_npc  <= {PC_W{1'b0}};
      skid_inst <= NOP_INST;
      skid_npc  <= {PC_W{1'b0}};
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state     <= ST_ONE;
            main_inst <= bus.instIn;
            main_npc  <= bus.NPCIn;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_inst <= bus.instIn;
            main_npc  <= bus.NPCIn;
          end else if (in_fire) begin
            // Decode stalled: park the newcomer behind main.
            state     <= ST_TWO;
            skid_inst <= bus.instIn;
            skid_npc  <= bus.NPCIn;
          end else if (out_fire) begin
            state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state     <= ST_ONE;
            main_inst <= skid_inst;
            main_npc  <= skid_npc;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where decode holds off a valid instruction; survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (out_vld && !bus.outReady && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: stream, stall/skid, flush, async reset, counter saturation.
// Latency: checks one-cycle pass-through and no-bubble streaming.
// Backpressure: checks inReady drop after skid fills and in-order drain.
module tb_if_id_skid_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] inst_in;
  logic [9:0]  npc_in;
  logic        flush;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_id_skid_reg_if #(.INST_W(32), .PC_W(10), .CNT_W(16)) bus ();
  if_id_skid_reg_if #(.INST_W(32), .PC_W(10), .CNT_W(3))  bus3 ();

  assign bus.inValid  = in_valid;
  assign bus.instIn   = inst_in;
  assign bus.NPCIn    = npc_in;
  assign bus.flush    = flush;
  assign bus.outReady = out_ready;

  assign bus3.inValid  = in_valid;
  assign bus3.instIn   = inst_in;
  assign bus3.NPCIn    = npc_in;
  assign bus3.flush    = flush;
  assign bus3.outReady = out_ready;

  if_id_skid_reg #(.INST_W(32), .PC_W(10), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  if_id_skid_reg #(.INST_W(32), .PC_W(10), .CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    inst_in   = 32'h0;
    npc_in    = 10'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_outValid", 32'(bus.outValid), 32'd0);
    chk("rst_inReady",  32'(bus.inReady),  32'd0);
    chk("rst_instOut",  bus.instOut,       32'd0);
    chk("rst_NPCOut",   32'(bus.NPCOut),   32'd0);
    chk("rst_stallCnt", 32'(bus.stallCnt), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("rel_inReady",  32'(bus.inReady),  32'd1);
    chk("rel_outValid", 32'(bus.outValid), 32'd0);

    // Stream with decode always ready.
    in_valid = 1'b1; out_ready = 1'b1; inst_in = 32'd50; npc_in = 10'd10;
    tick();
    chk("s1_outValid", 32'(bus.outValid), 32'd1);
    chk("s1_instOut",  bus.instOut,       32'd50);
    chk("s1_NPCOut",   32'(bus.NPCOut),   32'd10);
    inst_in = 32'd10; npc_in = 10'd50;
    tick();
    chk("s2_outValid", 32'(bus.outValid), 32'd1);
    chk("s2_instOut",  bus.instOut,       32'd10);
    chk("s2_NPCOut",   32'(bus.NPCOut),   32'd50);
    chk("s2_stallCnt", 32'(bus.stallCnt), 32'd0);
    in_valid = 1'b0;
    tick();
    chk("s3_outValid", 32'(bus.outValid), 32'd0);
    chk("s3_instOut",  bus.instOut,       32'd0);

    // Stall into skid.
    out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hA1; npc_in = 10'h1;
    tick();
    chk("k1_instOut",  bus.instOut,       32'hA1);
    chk("k1_inReady",  32'(bus.inReady),  32'd1);
    chk("k1_stallCnt", 32'(bus.stallCnt), 32'd0);
    inst_in = 32'hA2; npc_in = 10'h2;
    tick();
    chk("k2_inReady",  32'(bus.inReady),  32'd0);
    chk("k2_instOut",  bus.instOut,       32'hA1);
    chk("k2_stallCnt", 32'(bus.stallCnt), 32'd1);
    inst_in = 32'hA3; npc_in = 10'h3;
    tick();
    chk("k3_inReady",  32'(bus.inReady),  32'd0);
    chk("k3_instOut",  bus.instOut,       32'hA1);
    chk("k3_stallCnt", 32'(bus.stallCnt), 32'd2);
    out_ready = 1'b1;
    tick();
    chk("k4_instOut",  bus.instOut,       32'hA2);
    chk("k4_NPCOut",   32'(bus.NPCOut),   32'h2);
    chk("k4_inReady",  32'(bus.inReady),  32'd1);
    tick();
    chk("k5_instOut",  bus.instOut,       32'hA3);
    chk("k5_NPCOut",   32'(bus.NPCOut),   32'h3);
    chk("k5_stallCnt", 32'(bus.stallCnt), 32'd2);
    in_valid = 1'b0;
    tick();
    chk("k6_outValid", 32'(bus.outValid), 32'd0);

    // Flush with both entries full.
    out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hB1; npc_in = 10'h11;
    tick();
    inst_in = 32'hB2; npc_in = 10'h12;
    tick();
    chk("f0_inReady",  32'(bus.inReady),  32'd0);
    in_valid = 1'b0; flush = 1'b1;
    #1;
    chk("f0_instOut_in_flush_cycle", bus.instOut, 32'hB1);
    tick();
    flush = 1'b0;
    chk("f1_outValid", 32'(bus.outValid), 32'd0);
    chk("f1_instOut",  bus.instOut,       32'd0);
    chk("f1_NPCOut",   32'(bus.NPCOut),   32'd0);
    chk("f1_inReady",  32'(bus.inReady),  32'd1);
    chk("f1_stallCnt", 32'(bus.stallCnt), 32'd4);
    out_ready = 1'b1;
    tick();
    chk("f2_outValid", 32'(bus.outValid), 32'd0);

    // Flush in ONE with an instruction accepted in the same cycle.
    out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hC1; npc_in = 10'h21;
    tick();
    chk("g0_instOut", bus.instOut, 32'hC1);
    inst_in = 32'h77; npc_in = 10'h77; flush = 1'b1;
    #1;
    chk("g0_inReady", 32'(bus.inReady), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("g1_outValid", 32'(bus.outValid), 32'd0);
    chk("g1_instOut",  bus.instOut,       32'd0);
    chk("g1_stallCnt", 32'(bus.stallCnt), 32'd5);
    tick();
    chk("g2_outValid", 32'(bus.outValid), 32'd0);

    // Asynchronous reset while in TWO.
    out_ready = 1'b0; in_valid = 1'b1; inst_in = 32'hD1; npc_in = 10'h31;
    tick();
    inst_in = 32'hD2; npc_in = 10'h32;
    tick();
    in_valid = 1'b0;
    chk("r0_stallCnt", 32'(bus.stallCnt), 32'd6);
    chk("r0_inReady",  32'(bus.inReady),  32'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("r1_outValid", 32'(bus.outValid), 32'd0);
    chk("r1_inReady",  32'(bus.inReady),  32'd0);
    chk("r1_stallCnt", 32'(bus.stallCnt), 32'd0);
    chk("r1_instOut",  bus.instOut,       32'd0);
    tick();
    reset = 1'b1;
    #1;
    chk("r2_inReady",  32'(bus.inReady),  32'd1);
    chk("r2_outValid", 32'(bus.outValid), 32'd0);

    // Counter saturation on the 3-bit instance, 16-bit instance keeps counting.
    in_valid = 1'b1; inst_in = 32'hE1; npc_in = 10'h41;
    tick();
    in_valid = 1'b0;
    chk("c0_instOut3", bus3.instOut, 32'hE1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("c_stallCnt3", 32'(bus3.stallCnt), (i > 7) ? 32'd7 : 32'(i));
    end
    chk("c_stallCnt16", 32'(bus.stallCnt), 32'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
